alu_control_seq: RTL and testbench

Parametrised next-generation ALU control unit for the single-cycle MIPS datapath. Decodes `alu_op`/`funct` into the ALU operation select and shift direction, and adds a multi-cycle unsigned multiply/divide engine (`mul`, `divu`) with a stall handshake that freezes the PC and register write-back until the result is ready. It sits between the main control unit and the ALU; the ALU takes `md_lo` as its result whenever `op_code_Sel` is 3'b010.

---
 rtl/alu_control_seq.sv | 138 +++++++++++++
 tb/tb_alu_control_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// ALU control for the single-cycle MIPS datapath: combinational op/shift decode plus a
// multi-cycle unsigned mul/divu engine that stalls the pipeline until its result is ready.
module alu_control_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic             issue,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [2:0]       op_code_Sel,
   output logic             direction,
   output logic             stall,
   output logic [WIDTH-1:0] md_lo,
   output logic [WIDTH-1:0] md_hi,
   output logic             md_valid,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    count;
   logic             is_div;
   logic             dbz_q;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic             is_md, start, last_iter;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH:0]   mul_sum, rem_shift;
   logic             rem_ge;

   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      op_code_Sel = 3'b000;
      direction   = 1'b0;
      is_md       = 1'b0;
      case (alu_op)
         2'b00: op_code_Sel = 3'b000;
         2'b01: op_code_Sel = 3'b001;
         2'b11: op_code_Sel = 3'b100;
         default: begin
            case (funct)
               6'd32: op_code_Sel = 3'b000;
               6'd34: op_code_Sel = 3'b001;
               6'd33, 6'd27: begin
                  op_code_Sel = 3'b010;
                  is_md       = 1'b1;
               end
               6'd36: op_code_Sel = 3'b011;
               6'd37: op_code_Sel = 3'b100;
               6'd39: op_code_Sel = 3'b101;
               6'd0: begin
                  op_code_Sel = 3'b110;
                  direction   = 1'b1;
               end
               6'd2:  op_code_Sel = 3'b110;
               6'd3:  op_code_Sel = 3'b111;
               default: op_code_Sel = 3'b000;
            endcase
         end
      endcase
   end

   assign start     = (state == IDLE) && issue && is_md;
   assign last_iter = (count == CW'(WIDTH - 1));
   assign stall     = !rst && (start || (state == BUSY));
   assign md_valid  = !rst && (state == DONE);
   assign div_by_zero = md_valid && dbz_q;

   // One iteration: shift-add for mul (acc_lo holds the multiplier), restoring step for
   // divu (acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in).
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      rem_shift = {acc_hi, acc_lo[WIDTH-1]};
      rem_ge    = rem_shift >= {1'b0, opnd};
      if (is_div) begin
         step_hi = rem_ge ? (rem_shift[WIDTH-1:0] - opnd) : rem_shift[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], rem_ge};
      end else begin
         {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         md_lo  <= '0;
         md_hi  <= '0;
         dbz_q  <= 1'b0;
         is_div <= 1'b0;
         opnd   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div <= (funct == 6'd27);
                  opnd   <= (funct == 6'd27) ? src_b : src_a;
                  acc_lo <= (funct == 6'd27) ? src_a : src_b;
                  acc_hi <= '0;
                  count  <= '0;
               end
            end
            BUSY: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count + CW'(1);
               if (last_iter) begin
                  md_lo <= step_lo;
                  md_hi <= step_hi;
                  dbz_q <= is_div && (opnd == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: decode sweep, mul/divu scoreboard, abort and back-to-back.
module tb_alu_control_seq;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dbz;
   } md_res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   alu_op;
   logic [5:0]   funct;
   logic         issue;
   logic [W-1:0] src_a, src_b;
   logic [2:0]   op_code_Sel;
   logic         direction, stall, md_valid, div_by_zero;
   logic [W-1:0] md_lo, md_hi;

   md_res_t sb_q[$];
   int      n_cmp = 0;
   int      n_err = 0;
   int      cyc   = 0;

   alu_control_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .issue(issue),
      .src_a(src_a), .src_b(src_b), .op_code_Sel(op_code_Sel), .direction(direction),
      .stall(stall), .md_lo(md_lo), .md_hi(md_hi), .md_valid(md_valid),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every md_valid pops the oldest expected result.
   always @(negedge clk) begin
      md_res_t e;
      if (md_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("sb_md_lo", md_lo, e.lo);
            check("sb_md_hi", md_hi, e.hi);
            check("sb_div_by_zero", div_by_zero, e.dbz);
         end
      end
   end

   task automatic run_op(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, output int done_cyc);
      md_res_t      e;
      logic [2*W-1:0] p;
      int           stalls;
      bit           seen;
      if (div) begin
         e.lo  = (b == 0) ? '1 : a / b;
         e.hi  = (b == 0) ? a : a % b;
         e.dbz = (b == 0);
      end else begin
         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         {e.hi, e.lo} = p;
         e.dbz = 1'b0;
      end
      sb_q.push_back(e);
      @(posedge clk); #1;
      issue  = 1'b1;
      alu_op = 2'b10;
      funct  = div ? 6'd27 : 6'd33;
      src_a  = a;
      src_b  = b;
      stalls = 0;
      seen   = 1'b0;
      done_cyc = -1;
      for (int c = 0; c < 3 * W && !seen; c++) begin
         @(negedge clk);
         if (md_valid) begin
            seen = 1'b1;
            done_cyc = cyc;
            check({tag, "_stall_at_done"}, stall, 0);
         end else if (stall) begin
            stalls++;
         end
         if (c == 1) begin
            src_a = $urandom;
            src_b = $urandom;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_stall_cycles"}, stalls, W + 1);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      issue = 1'b0;
   endtask

   logic [1:0] d_aop [14] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
   logic [5:0] d_fn  [14] = '{6'd5, 6'd0, 6'd0, 6'd32, 6'd34, 6'd33, 6'd27, 6'd36,
                              6'd37, 6'd39, 6'd0, 6'd2, 6'd3, 6'd50};
   logic [2:0] d_op  [14] = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b001, 3'b010, 3'b010, 3'b011,
                              3'b100, 3'b101, 3'b110, 3'b110, 3'b111, 3'b000};
   logic       d_dir [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      int d1, d2, dd, n_valid;
      rst    = 1'b1;
      issue  = 1'b1;
      alu_op = 2'b10;
      funct  = 6'd33;
      src_a  = 7;
      src_b  = 6;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_md_lo", md_lo, 0);
      check("rst_md_hi", md_hi, 0);
      check("rst_md_valid", md_valid, 0);
      check("rst_div_by_zero", div_by_zero, 0);
      @(posedge clk); #1;
      rst   = 1'b0;
      issue = 1'b0;

      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         alu_op = d_aop[i];
         funct  = d_fn[i];
         @(negedge clk);
         check($sformatf("dec%0d_op", i), op_code_Sel, d_op[i]);
         check($sformatf("dec%0d_dir", i), direction, d_dir[i]);
         check($sformatf("dec%0d_stall", i), stall, 0);
      end

      @(posedge clk); #1;
      issue  = 1'b1;
      alu_op = 2'b10;
      funct  = 6'd32;
      repeat (2) begin
         @(negedge clk);
         check("non_md_issue_stall", stall, 0);
      end

      run_op(1'b0, 32'd7, 32'd6, "mul7x6", dd);
      go_idle();
      @(negedge clk);
      check("hold_md_lo", md_lo, 42);
      check("hold_md_valid", md_valid, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd2, "mul_max2", dd);
      go_idle();
      run_op(1'b1, 32'd100, 32'd7, "divu100_7", dd);
      go_idle();
      run_op(1'b1, 32'd5, 32'd0, "divu5_0", dd);
      go_idle();
      @(negedge clk);
      check("dbz_low_in_idle", div_by_zero, 0);
      for (int i = 0; i < 2; i++) begin
         run_op(1'b0, $urandom, $urandom, "mul_rand", dd);
         go_idle();
         run_op(1'b1, $urandom, (i == 0) ? W'($urandom_range(1, 1000)) : W'($urandom),
                "divu_rand", dd);
         go_idle();
      end

      // Abort a mul while BUSY at count 10.
      @(posedge clk); #1;
      issue  = 1'b1;
      alu_op = 2'b10;
      funct  = 6'd33;
      src_a  = 123;
      src_b  = 456;
      repeat (11) @(posedge clk);
      #1;
      rst   = 1'b1;
      issue = 1'b0;
      @(negedge clk);
      check("abort_stall_in_rst", stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_stall", stall, 0);
      check("abort_md_valid", md_valid, 0);
      check("abort_md_lo", md_lo, 0);
      check("abort_md_hi", md_hi, 0);
      n_valid = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_valid) n_valid++;
      end
      check("abort_no_result", n_valid, 0);

      run_op(1'b0, 32'd3, 32'd3, "b2b_mul", d1);
      run_op(1'b1, 32'd9, 32'd2, "b2b_div", d2);
      check("b2b_spacing", d2 - d1, W + 2);
      go_idle();
      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
